// File: rtl/fp_mul_pkg.sv
// Shared sizing and state type for the iterative significand multiplier.
package fp_mul_pkg;

    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_mant_normalize.sv
// Combinational normalize/truncate of the raw significand product in [1,4).
module fp_mant_normalize
    import fp_mul_pkg::*;
(
    input  logic [PROD_W-1:0] i_prod,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_norm,
    output logic              o_inexact
);

    // Top bit set means the product is >= 2.0: drop one more bit into the sticky OR.
    always_comb begin
        o_norm = i_prod[PROD_W-1];
        if (i_prod[PROD_W-1]) begin
            o_frac    = i_prod[PROD_W-2 -: FRAC_W];
            o_inexact = |i_prod[SIG_W-1:0];
        end else begin
            o_frac    = i_prod[PROD_W-3 -: FRAC_W];
            o_inexact = |i_prod[SIG_W-2:0];
        end
    end

endmodule

// File: rtl/fp_mant_mul_seq.sv
// Shift-and-add significand multiplier with valid/ready on both sides;
// one operation in flight, SIG_W iterations per product.
module fp_mant_mul_seq
    import fp_mul_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sign_a,
    input  logic              i_sign_b,
    input  logic [FRAC_W-1:0] i_frac_a,
    input  logic [FRAC_W-1:0] i_frac_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sign,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_norm,
    output logic              o_inexact
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ready;
    logic                r_valid;
    logic                r_sign;
    logic [FRAC_W-1:0]   r_frac;
    logic                r_norm;
    logic                r_inexact;
    logic [PROD_W-1:0]   r_mcand;
    logic [SIG_W-1:0]    r_mplr;
    logic [PROD_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_finish;
    logic                w_release;
    logic [PROD_W-1:0]   w_acc_sum;
    logic [FRAC_W-1:0]   w_frac;
    logic                w_norm;
    logic                w_inexact;

    assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_count == CNT_W'(SIG_W - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The final iteration's sum is normalized directly so results land on the same edge.
    fp_mant_normalize u_norm (
        .i_prod    (w_acc_sum),
        .o_frac    (w_frac),
        .o_norm    (w_norm),
        .o_inexact (w_inexact)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_sign    <= 1'b0;
            r_frac    <= '0;
            r_norm    <= 1'b0;
            r_inexact <= 1'b0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_acc     <= '0;
            r_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_mcand <= PROD_W'({1'b1, i_frac_a});
                r_mplr  <= {1'b1, i_frac_b};
                r_acc   <= '0;
                r_count <= '0;
                r_sign  <= i_sign_a ^ i_sign_b;
            end
            if (r_state == BUSY) begin
                r_acc   <= w_acc_sum;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_count <= r_count + CNT_W'(1);
            end
            if (w_finish) begin
                r_frac    <= w_frac;
                r_norm    <= w_norm;
                r_inexact <= w_inexact;
                r_valid   <= 1'b1;
            end
            if (w_release) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_valid;
    assign o_sign    = r_sign;
    assign o_frac    = r_frac;
    assign o_norm    = r_norm;
    assign o_inexact = r_inexact;

endmodule

// File: tb/tb_fp_mant_mul_seq.sv
// Directed bench for fp_mant_mul_seq: hand-computed products, latency, backpressure, reset.
module tb_fp_mant_mul_seq;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic       i_sign_a;
    logic       i_sign_b;
    logic [9:0] i_frac_a;
    logic [9:0] i_frac_b;
    logic       o_valid;
    logic       i_ready;
    logic       o_sign;
    logic [9:0] o_frac;
    logic       o_norm;
    logic       o_inexact;

    int n_checks = 0;
    int n_pass   = 0;

    fp_mant_mul_seq dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sign_a  (i_sign_a),
        .i_sign_b  (i_sign_b),
        .i_frac_a  (i_frac_a),
        .i_frac_b  (i_frac_b),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_sign    (o_sign),
        .o_frac    (o_frac),
        .o_norm    (o_norm),
        .o_inexact (o_inexact)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Present operands at a falling edge; accepted at the following rising edge.
    task automatic issue(input logic [9:0] a, input logic [9:0] b, input logic sa, input logic sb);
        i_frac_a = a;
        i_frac_b = b;
        i_sign_a = sa;
        i_sign_b = sb;
        i_valid  = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Returns number of rising edges after acceptance until o_valid, or 0 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        check({tag, "_valid_low"}, 32'(o_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [9:0] a, input logic [9:0] b,
                          input logic sa, input logic sb, input logic [9:0] ef,
                          input logic en, input logic ei, input logic es);
        int lat;
        issue(a, b, sa, sb);
        check({tag, "_ready_busy"}, 32'(o_ready), 32'd0);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_frac"}, 32'(o_frac), 32'(ef));
        check({tag, "_norm"}, 32'(o_norm), 32'(en));
        check({tag, "_inexact"}, 32'(o_inexact), 32'(ei));
        check({tag, "_sign"}, 32'(o_sign), 32'(es));
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  saw_valid;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_sign_a = 1'b0;
        i_sign_b = 1'b0;
        i_frac_a = '0;
        i_frac_b = '0;

        // Reset held for three cycles.
        repeat (3) @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_outs", {28'd0, o_sign, o_norm, o_inexact, |o_frac}, 32'd0);
        i_rst_n = 1'b1;
        check("rel_ready_pre", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("rel_ready_post", 32'(o_ready), 32'd1);

        // 1.0 x 1.0 = 1.0
        run_op("one", 10'h000, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        // 1.5 x 1.5 = 2.25 -> 1.125 * 2
        run_op("p15", 10'h200, 10'h200, 1'b1, 1'b0, 10'h080, 1'b1, 1'b0, 1'b1);
        // (2-2^-10)^2, P = 0x3FF001
        run_op("max", 10'h3FF, 10'h3FF, 1'b1, 1'b1, 10'h3FE, 1'b1, 1'b1, 1'b0);

        // Backpressure: 1.75 x 1.75 = 3.0625, held for 5 cycles.
        issue(10'h300, 10'h300, 1'b0, 1'b1);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd11);
        i_frac_a = 10'h000;
        i_frac_b = 10'h000;
        i_sign_a = 1'b0;
        i_sign_b = 1'b0;
        i_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid_hold", 32'(o_valid), 32'd1);
            check("bp_frac_hold", 32'(o_frac), 32'h220);
            check("bp_norm_hold", 32'(o_norm), 32'd1);
            check("bp_sign_hold", 32'(o_sign), 32'd1);
            check("bp_ready_low", 32'(o_ready), 32'd0);
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        check("bp_release_valid", 32'(o_valid), 32'd0);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("bp_next_accepted", 32'(o_ready), 32'd0);
        wait_valid(lat);
        check("bp_next_latency", 32'(lat), 32'd11);
        check("bp_next_frac", 32'(o_frac), 32'h000);
        check("bp_next_norm", 32'(o_norm), 32'd0);
        release_result("bp_next");

        // Reset during BUSY at count = 5.
        issue(10'h3FF, 10'h3FF, 1'b1, 1'b0);
        repeat (5) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(o_ready), 32'd0);
        check("mid_rst_outs", {28'd0, o_sign, o_norm, o_inexact, |o_frac}, 32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_result", 32'(saw_valid), 32'd0);
        check("mid_rst_ready_back", 32'(o_ready), 32'd1);
        run_op("after_rst", 10'h200, 10'h200, 1'b0, 1'b0, 10'h080, 1'b1, 1'b0, 1'b0);

        // i_ready while idle has no effect.
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        check("idle_ready_valid", 32'(o_valid), 32'd0);
        check("idle_ready_ready", 32'(o_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
